sw_event_core: RTL
==================

# sw_event_core

MMIO slot core that debounces the board slide switches and turns each debounced edge into a time-stamped event word queued in a small FIFO for software to drain. It plugs into one slot of the vanilla MMIO subsystem, downstream of the MCS bridge, and replaces polling of raw switch levels. It uses the standard slot bus: chip select, read/write strobes, 5-bit word address, and 32-bit data.

## Interface
- W, 16: number of switch inputs (1..32)
- DB_CNT, 1_000_000: clocks per debounce sample tick (10 ms at 100 MHz); must exceed 2*W
- FIFO_AW, 4: event FIFO address width (depth 2**FIFO_AW)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- cs  in  1  slot select
- read  in  1  read strobe (qualified by cs)
- write  in  1  write strobe (qualified by cs)
- addr  in  5  word address within slot
- wr_data  in  32  write data
- rd_data  out  32  read data, combinational from addr
- din  in  W  raw asynchronous switch inputs

## Operation
- din passes through a 2-FF synchronizer into sync.
- A tick counter counts 0..DB_CNT-1 and asserts tick for one cycle at DB_CNT-1. On tick: samp <= sync; for each bit, db[i] <= (sync[i]==samp[i]) ? sync[i] : db[i].
- Edge detect: db changing 0->1 sets rise_pend[i] if ctrl.rise_en; 1->0 sets fall_pend[i] if ctrl.fall_en.
- Scanner: each cycle picks the lowest index i with rise_pend|fall_pend set; rise wins over fall for the same bit. It clears that pend bit and pushes event {ts[15:0], 7'b0, pol, index[7:0]} (pol=1 rise).
- FIFO full on push: event dropped, pend bit still cleared, sticky ovf set. Full with a simultaneous pop: push accepted, no ovf.
- Registers (word addr):
  - 0 R: db (zero-extended)
  - 1 R: {count[15:0] at [23:8], ovf[2], full[1], empty[0]}
  - 2 R: FIFO head, non-destructive; 0 when empty
  - 3 W: any write pops one entry; a pop on empty is ignored
  - 4 R/W: ctrl {flush[3], clr_ovf[2], fall_en[1], rise_en[0]}. flush and clr_ovf are self-clearing and read back 0.
- flush empties the FIFO and clears all pend bits. A flush in the same cycle as a push or pop takes priority; the push is lost without setting ovf.
- Writes to addresses 0-2 and 5-31 are ignored. Reads of unmapped addresses return 0.

## Timing
- Reset values: rd_data follows addr (registers all zero, empty=1); db, samp, pend, ovf, ctrl, ts, and the tick counter are all 0. FIFO is empty.
- Debounce latency from a stable din change to db: 2 sync cycles plus between 1 and 2 tick periods. A glitch shorter than one tick period never reaches db.
- db to pend: 1 cycle. Pend to FIFO push: 1 cycle after the scanner selects it. K simultaneous edges enqueue over K consecutive cycles.
- A pop write in cycle N: head and count update visible in cycle N+1.
- ts increments on every tick and wraps from 0xFFFF to 0. The event carries the ts value current at the push cycle.
- Reset mid-operation: everything returns to reset values in the next cycle and pending events are discarded.

## Configuration
- SW_EVENT_TIMESTAMP_EN defined: ts counter is present, FIFO is 32 bits wide, and event bits [31:16] hold ts.
- Not defined: no ts counter, FIFO is 9 bits wide ({pol, index}), and bits [31:16] read 0. All other behaviour is identical.

## Structure
- Package sw_event_pkg holds:
  - register address constants (REG_DB=0, REG_STAT=1, REG_HEAD=2, REG_POP=3, REG_CTRL=4)
  - ctrl bit positions
  - event field positions (IDX_LSB, POL_BIT, TS_LSB)
- Sub-module sw_event_fifo: synchronous FWFT FIFO with parameterised data width and FIFO_AW. Ports: push, pop, flush, din, dout, empty, full, count. Handles simultaneous push and pop when full.
- Debounce, scanner, and register decode stay in the top module.

## Test plan
- Reset, then read regs 0/1/2/4 -> 0, 0x1 (empty), 0, 0.
- rise_en=1, din[3] 0->1 held for 3 ticks (DB_CNT=16 in sim) -> reg0=0x8; head=0x103; count=1. A pop write then reads empty=1.
- din[5] glitches high for DB_CNT/2 cycles -> db unchanged, FIFO stays empty.
- rise_en|fall_en, din 0x0000->0x0011 -> two events in order 0x100 then 0x104, on consecutive push cycles.
- FIFO_AW=2, 5 rising edges without pops -> count=4, ovf=1. Write clr_ovf -> ovf=0. Flush -> empty=1, count=0.
- With SW_EVENT_TIMESTAMP_EN, edge after 7 ticks -> head[31:16]=7. Without the macro -> head[31:16]=0.

Source files
------------

// File: rtl/sw_event_pkg.sv
// Shared constants and payload types for the switch event slot core.
// Holds register word addresses, ctrl/status bit positions and the
// layout of the event word that software pops from the FIFO.
package sw_event_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  // Register word addresses within the slot
  localparam logic [ADDR_W-1:0] REG_DB   = 5'd0;
  localparam logic [ADDR_W-1:0] REG_STAT = 5'd1;
  localparam logic [ADDR_W-1:0] REG_HEAD = 5'd2;
  localparam logic [ADDR_W-1:0] REG_POP  = 5'd3;
  localparam logic [ADDR_W-1:0] REG_CTRL = 5'd4;

  // ctrl register bit positions (flush/clr_ovf are write-only pulses)
  localparam int unsigned CTRL_RISE_EN = 0;
  localparam int unsigned CTRL_FALL_EN = 1;
  localparam int unsigned CTRL_CLR_OVF = 2;
  localparam int unsigned CTRL_FLUSH   = 3;

  // status register bit positions
  localparam int unsigned STAT_EMPTY   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 8;
  localparam int unsigned STAT_CNT_W   = 16;

  // event word field positions
  localparam int unsigned IDX_LSB = 0;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned POL_BIT = 8;
  localparam int unsigned TS_LSB  = 16;
  localparam int unsigned TS_W    = 16;

  // Full event word as seen by software
  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [6:0]       rsvd;
    logic             pol;
    logic [IDX_W-1:0] idx;
  } event_t;

  // Persistent ctrl state (bit 1 = fall_en, bit 0 = rise_en)
  typedef struct packed {
    logic fall_en;
    logic rise_en;
  } ctrl_t;

endpackage

// File: rtl/sw_event_fifo.sv
// Synchronous first-word-fall-through FIFO for switch events.
// Ports: clk, reset (sync, active-high), push/pop/flush strobes,
// din/dout data, empty/full flags, count of stored entries.
// A push while full is accepted only when a pop happens the same cycle;
// a pop on empty is ignored; flush overrides push and pop.
module sw_event_fifo #(
  parameter int unsigned DW = 9,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push_c, do_pop_c;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push_c && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sw_event_core.sv
// MMIO slot core: debounces slide switches and queues one event word per
// debounced edge for software to drain.
// Ports: clk, reset (sync, active-high), cs/read/write/addr/wr_data slot
// bus, rd_data (combinational from addr), din raw switch inputs.
// Optional build macro SW_EVENT_TIMESTAMP_EN adds a 16-bit tick timestamp
// to bits [31:16] of every event; without it those bits read 0.
module sw_event_core
  import sw_event_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned DB_CNT  = 1_000_000,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic [W-1:0]      din
);

  localparam int unsigned CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);
`ifdef SW_EVENT_TIMESTAMP_EN
  localparam int unsigned EV_W = DATA_W;
`else
  localparam int unsigned EV_W = IDX_W + 1;
`endif

  // State
  logic [W-1:0]     sync1_q, sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     samp_q, samp_d;
  logic [W-1:0]     db_q, db_d, db_prev_q;
  logic [W-1:0]     rise_pend_q, rise_pend_d;
  logic [W-1:0]     fall_pend_q, fall_pend_d;
  logic             ev_vld_q, ev_vld_d;
  logic             ev_pol_q, ev_pol_d;
  logic [IDX_W-1:0] ev_idx_q, ev_idx_d;
  logic             ovf_q, ovf_d;
  ctrl_t            ctrl_q, ctrl_d;

  // Combinational helpers
  logic             tick_c;
  logic [W-1:0]     rise_c, fall_c;
  logic             sel_found_c, sel_pol_c;
  logic [IDX_W-1:0] sel_idx_c;
  logic [W-1:0]     sel_oh_c;
  logic             wr_ctrl_c, pop_c, flush_c, clr_ovf_c;
  logic             ovf_set_c;

  // FIFO interface
  logic [EV_W-1:0]  fifo_din, fifo_dout;
  logic             fifo_empty, fifo_full;
  logic [FIFO_AW:0] fifo_count;

  logic unused_c;
  assign unused_c = ^{read, wr_data[DATA_W-1:CTRL_FLUSH+1]};

  // Bus decode
  assign wr_ctrl_c = cs & write & (addr == REG_CTRL);
  assign pop_c     = cs & write & (addr == REG_POP);
  assign flush_c   = wr_ctrl_c & wr_data[CTRL_FLUSH];
  assign clr_ovf_c = wr_ctrl_c & wr_data[CTRL_CLR_OVF];

  assign tick_c = (cnt_q == CNT_MAX);

  // Debounced edges, one cycle after db moves
  assign rise_c = db_q & ~db_prev_q;
  assign fall_c = ~db_q & db_prev_q;

  // Tick counter and two-sample debounce
  always_comb begin
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    samp_d = samp_q;
    db_d   = db_q;
    if (tick_c) begin
      samp_d = sync_q;
      // A bit only follows sync when two consecutive samples agree
      db_d   = (~(sync_q ^ samp_q) & sync_q) | ((sync_q ^ samp_q) & db_q);
    end
  end

  // Priority scanner: lowest pending index, rise before fall
  always_comb begin
    sel_found_c = 1'b0;
    sel_pol_c   = 1'b0;
    sel_idx_c   = '0;
    sel_oh_c    = '0;
    for (int i = 0; i < W; i++) begin
      if (!sel_found_c && (rise_pend_q[i] || fall_pend_q[i])) begin
        sel_found_c = 1'b1;
        sel_pol_c   = rise_pend_q[i];
        sel_idx_c   = IDX_W'(i);
        sel_oh_c[i] = 1'b1;
      end
    end
  end

  // Pending bits, event staging, ctrl and overflow next-state
  always_comb begin
    rise_pend_d = rise_pend_q;
    fall_pend_d = fall_pend_q;
    ev_vld_d    = 1'b0;
    ev_pol_d    = ev_pol_q;
    ev_idx_d    = ev_idx_q;
    ctrl_d      = ctrl_q;
    ovf_d       = ovf_q;

    if (flush_c) begin
      rise_pend_d = '0;
      fall_pend_d = '0;
    end else begin
      // New edges win over the scanner clearing the same bit
      rise_pend_d = (rise_pend_q & ~(sel_pol_c ? sel_oh_c : '0))
                  | (rise_c & {W{ctrl_q.rise_en}});
      fall_pend_d = (fall_pend_q & ~(sel_pol_c ? '0 : sel_oh_c))
                  | (fall_c & {W{ctrl_q.fall_en}});
      ev_vld_d    = sel_found_c;
      ev_pol_d    = sel_pol_c;
      ev_idx_d    = sel_idx_c;
    end

    if (wr_ctrl_c) begin
      ctrl_d.rise_en = wr_data[CTRL_RISE_EN];
      ctrl_d.fall_en = wr_data[CTRL_FALL_EN];
    end

    if (clr_ovf_c) ovf_d = 1'b0;
    if (ovf_set_c) ovf_d = 1'b1;
  end

  // Drop happens only when full with no pop and no flush in the same cycle
  assign ovf_set_c = ev_vld_q & ~flush_c & fifo_full & ~pop_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      cnt_q       <= '0;
      samp_q      <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      rise_pend_q <= '0;
      fall_pend_q <= '0;
      ev_vld_q    <= 1'b0;
      ev_pol_q    <= 1'b0;
      ev_idx_q    <= '0;
      ovf_q       <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      sync1_q     <= din;
      sync_q      <= sync1_q;
      cnt_q       <= cnt_d;
      samp_q      <= samp_d;
      db_q        <= db_d;
      db_prev_q   <= db_q;
      rise_pend_q <= rise_pend_d;
      fall_pend_q <= fall_pend_d;
      ev_vld_q    <= ev_vld_d;
      ev_pol_q    <= ev_pol_d;
      ev_idx_q    <= ev_idx_d;
      ovf_q       <= ovf_d;
      ctrl_q      <= ctrl_d;
    end
  end

`ifdef SW_EVENT_TIMESTAMP_EN
  // Free-running timestamp advanced once per debounce tick
  logic [TS_W-1:0] ts_q;
  event_t          ev_word_c;

  always_ff @(posedge clk) begin
    if (reset)       ts_q <= '0;
    else if (tick_c) ts_q <= ts_q + TS_W'(1);
  end

  always_comb begin
    ev_word_c     = '0;
    ev_word_c.ts  = ts_q;
    ev_word_c.pol = ev_pol_q;
    ev_word_c.idx = ev_idx_q;
  end

  assign fifo_din = ev_word_c;
`else
  assign fifo_din = {ev_pol_q, ev_idx_q};
`endif

  sw_event_fifo #(
    .DW (EV_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev_vld_q),
    .pop   (pop_c),
    .flush (flush_c),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Read mux, unmapped addresses return 0
  always_comb begin
    rd_data = '0;
    case (addr)
      REG_DB: rd_data = DATA_W'(db_q);
      REG_STAT: begin
        rd_data[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
        rd_data[STAT_OVF]   = ovf_q;
        rd_data[STAT_FULL]  = fifo_full;
        rd_data[STAT_EMPTY] = fifo_empty;
      end
      REG_HEAD: if (!fifo_empty) rd_data = DATA_W'(fifo_dout);
      REG_CTRL: rd_data = DATA_W'(ctrl_q);
      default:  rd_data = '0;
    endcase
  end

endmodule
